// File: rtl/z80_irq_pkg.sv
// Shared types and constants for the Z80 interrupt-control block.
package z80_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_ACK2  = 2'd2,
    ST_OFFER = 2'd3
  } irq_state_e;

  localparam logic [15:0] VEC_NMI = 16'h0066;
  localparam logic [15:0] VEC_IM1 = 16'h0038;

  localparam logic [1:0] IM_MODE0 = 2'd0;
  localparam logic [1:0] IM_MODE1 = 2'd1;
  localparam logic [1:0] IM_MODE2 = 2'd2;

  // The undefined IM encoding behaves as IM 1.
  function automatic logic [1:0] im_sanitize(input logic [1:0] n);
    return (n == 2'd3) ? IM_MODE1 : n;
  endfunction

endpackage

// File: rtl/z80_nmi_edge.sv
// Two-flop synchronizer for /NMI plus a one-cycle falling-edge pulse.
module z80_nmi_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic nmi_n,
  output logic nmi_fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = nmi_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Flops reset to the inactive (high) level so release from reset is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign nmi_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/z80_irq_ctrl.sv
// Z80 interrupt control: IFF1/IFF2, IM, EI shadow, NMI latch and acknowledge sequencing.
// Optional boundary trace ports are enabled by defining Z80FI_IRQ_TRACE_EN.
module z80_irq_ctrl
  import z80_irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        insn_done,
  input  logic        insn_ei,
  input  logic        insn_di,
  input  logic        insn_retn,
  input  logic        insn_im_wr,
  input  logic [1:0]  insn_im,
  input  logic        int_n,
  input  logic        nmi_n,
  input  logic [7:0]  i_reg,
  input  logic [7:0]  ack_data,
  output logic        intack,
  output logic        svc_valid,
  input  logic        svc_ready,
  output logic        svc_nmi,
  output logic        svc_indirect,
  output logic [15:0] svc_vector,
  output logic        iff1,
  output logic        iff2,
  output logic [1:0]  im
`ifdef Z80FI_IRQ_TRACE_EN
  ,
  output logic        trace_valid,
  output logic        trace_iff1_in,
  output logic        trace_iff2_in,
  output logic        trace_iff1_out,
  output logic        trace_iff2_out
`endif
);

  irq_state_e  state_q, state_d;
  logic        iff1_q, iff1_d;
  logic        iff2_q, iff2_d;
  logic        shadow_q, shadow_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic [1:0]  im_q, im_d;
  logic        intack_q, intack_d;
  logic        svc_valid_q, svc_valid_d;
  logic        svc_nmi_q, svc_nmi_d;
  logic        svc_indirect_q, svc_indirect_d;
  logic [15:0] svc_vector_q, svc_vector_d;
  logic        nmi_fall;
  logic        boundary;
  logic        int_take;

  z80_nmi_edge u_nmi_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .nmi_n    (nmi_n),
    .nmi_fall (nmi_fall)
  );

  assign boundary = insn_done && (state_q == ST_IDLE);
  assign int_take = !int_n && iff1_q && !shadow_q && !insn_ei && !insn_di;

  always_comb begin
    state_d        = state_q;
    iff1_d         = iff1_q;
    iff2_d         = iff2_q;
    shadow_d       = shadow_q;
    im_d           = im_q;
    nmi_pending_d  = nmi_pending_q | nmi_fall;
    intack_d       = intack_q;
    svc_valid_d    = svc_valid_q;
    svc_nmi_d      = svc_nmi_q;
    svc_indirect_d = svc_indirect_q;
    svc_vector_d   = svc_vector_q;

    unique case (state_q)
      ST_IDLE: begin
        if (insn_done) begin
          // Instruction effects first; acceptance below uses the pre-update
          // iff1/shadow and overrides the flip-flops where it fires.
          if (insn_ei) begin
            iff1_d   = 1'b1;
            iff2_d   = 1'b1;
            shadow_d = 1'b1;
          end else if (insn_di) begin
            iff1_d   = 1'b0;
            iff2_d   = 1'b0;
            shadow_d = 1'b0;
          end else begin
            shadow_d = 1'b0;
            if (insn_retn) begin
              iff1_d = iff2_q;
            end
          end
          if (insn_im_wr) begin
            im_d = im_sanitize(insn_im);
          end

          if (nmi_pending_q) begin
            // A fresh edge arriving in the same cycle stays latched.
            nmi_pending_d  = nmi_fall;
            iff1_d         = 1'b0;
            svc_valid_d    = 1'b1;
            svc_nmi_d      = 1'b1;
            svc_indirect_d = 1'b0;
            svc_vector_d   = VEC_NMI;
            state_d        = ST_OFFER;
          end else if (int_take) begin
            iff1_d   = 1'b0;
            iff2_d   = 1'b0;
            intack_d = 1'b1;
            state_d  = ST_ACK1;
          end
        end
      end

      ST_ACK1: begin
        intack_d = 1'b1;
        state_d  = ST_ACK2;
      end

      ST_ACK2: begin
        intack_d    = 1'b0;
        svc_valid_d = 1'b1;
        svc_nmi_d   = 1'b0;
        state_d     = ST_OFFER;
        unique case (im_q)
          IM_MODE0: begin
            svc_indirect_d = 1'b0;
            svc_vector_d   = {8'h00, ack_data & 8'h38};
          end
          IM_MODE2: begin
            svc_indirect_d = 1'b1;
            svc_vector_d   = {i_reg, ack_data & 8'hFE};
          end
          default: begin
            svc_indirect_d = 1'b0;
            svc_vector_d   = VEC_IM1;
          end
        endcase
      end

      ST_OFFER: begin
        if (svc_ready) begin
          svc_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      iff1_q         <= 1'b0;
      iff2_q         <= 1'b0;
      shadow_q       <= 1'b0;
      im_q           <= IM_MODE0;
      nmi_pending_q  <= 1'b0;
      intack_q       <= 1'b0;
      svc_valid_q    <= 1'b0;
      svc_nmi_q      <= 1'b0;
      svc_indirect_q <= 1'b0;
      svc_vector_q   <= '0;
    end else begin
      state_q        <= state_d;
      iff1_q         <= iff1_d;
      iff2_q         <= iff2_d;
      shadow_q       <= shadow_d;
      im_q           <= im_d;
      nmi_pending_q  <= nmi_pending_d;
      intack_q       <= intack_d;
      svc_valid_q    <= svc_valid_d;
      svc_nmi_q      <= svc_nmi_d;
      svc_indirect_q <= svc_indirect_d;
      svc_vector_q   <= svc_vector_d;
    end
  end

  assign intack       = intack_q;
  assign svc_valid    = svc_valid_q;
  assign svc_nmi      = svc_nmi_q;
  assign svc_indirect = svc_indirect_q;
  assign svc_vector   = svc_vector_q;
  assign iff1         = iff1_q;
  assign iff2         = iff2_q;
  assign im           = im_q;

`ifdef Z80FI_IRQ_TRACE_EN
  logic trace_valid_q, trace_valid_d;
  logic trace_iff1_in_q, trace_iff1_in_d;
  logic trace_iff2_in_q, trace_iff2_in_d;
  logic trace_iff1_out_q, trace_iff1_out_d;
  logic trace_iff2_out_q, trace_iff2_out_d;

  // Snapshot of the flip-flops across each boundary, held until the next one.
  always_comb begin
    trace_valid_d    = boundary;
    trace_iff1_in_d  = trace_iff1_in_q;
    trace_iff2_in_d  = trace_iff2_in_q;
    trace_iff1_out_d = trace_iff1_out_q;
    trace_iff2_out_d = trace_iff2_out_q;
    if (boundary) begin
      trace_iff1_in_d  = iff1_q;
      trace_iff2_in_d  = iff2_q;
      trace_iff1_out_d = iff1_d;
      trace_iff2_out_d = iff2_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid_q    <= 1'b0;
      trace_iff1_in_q  <= 1'b0;
      trace_iff2_in_q  <= 1'b0;
      trace_iff1_out_q <= 1'b0;
      trace_iff2_out_q <= 1'b0;
    end else begin
      trace_valid_q    <= trace_valid_d;
      trace_iff1_in_q  <= trace_iff1_in_d;
      trace_iff2_in_q  <= trace_iff2_in_d;
      trace_iff1_out_q <= trace_iff1_out_d;
      trace_iff2_out_q <= trace_iff2_out_d;
    end
  end

  assign trace_valid    = trace_valid_q;
  assign trace_iff1_in  = trace_iff1_in_q;
  assign trace_iff2_in  = trace_iff2_in_q;
  assign trace_iff1_out = trace_iff1_out_q;
  assign trace_iff2_out = trace_iff2_out_q;
`endif

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Directed self-checking bench for z80_irq_ctrl with a service-request scoreboard.
module tb_z80_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        insn_done = 1'b0;
  logic        insn_ei = 1'b0;
  logic        insn_di = 1'b0;
  logic        insn_retn = 1'b0;
  logic        insn_im_wr = 1'b0;
  logic [1:0]  insn_im = 2'd0;
  logic        int_n = 1'b1;
  logic        nmi_n = 1'b1;
  logic [7:0]  i_reg = 8'h00;
  logic [7:0]  ack_data = 8'h00;
  logic        intack;
  logic        svc_valid;
  logic        svc_ready = 1'b0;
  logic        svc_nmi;
  logic        svc_indirect;
  logic [15:0] svc_vector;
  logic        iff1;
  logic        iff2;
  logic [1:0]  im;

  typedef struct packed {
    logic        nmi;
    logic        indirect;
    logic [15:0] vector;
  } svc_t;

  svc_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  z80_irq_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .insn_done    (insn_done),
    .insn_ei      (insn_ei),
    .insn_di      (insn_di),
    .insn_retn    (insn_retn),
    .insn_im_wr   (insn_im_wr),
    .insn_im      (insn_im),
    .int_n        (int_n),
    .nmi_n        (nmi_n),
    .i_reg        (i_reg),
    .ack_data     (ack_data),
    .intack       (intack),
    .svc_valid    (svc_valid),
    .svc_ready    (svc_ready),
    .svc_nmi      (svc_nmi),
    .svc_indirect (svc_indirect),
    .svc_vector   (svc_vector),
    .iff1         (iff1),
    .iff2         (iff2),
    .im           (im)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic svc_t mk(input logic n, input logic ind, input logic [15:0] v);
    svc_t s;
    s.nmi      = n;
    s.indirect = ind;
    s.vector   = v;
    return s;
  endfunction

  task automatic boundary(input logic ei, input logic di, input logic retn,
                          input logic imwr, input logic [1:0] imv);
    insn_done  = 1'b1;
    insn_ei    = ei;
    insn_di    = di;
    insn_retn  = retn;
    insn_im_wr = imwr;
    insn_im    = imv;
    step();
    insn_done  = 1'b0;
    insn_ei    = 1'b0;
    insn_di    = 1'b0;
    insn_retn  = 1'b0;
    insn_im_wr = 1'b0;
    insn_im    = 2'd0;
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    while (svc_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("svc_valid_arrives", 32'(svc_valid), 32'd1);
  endtask

  // Pops the expected request, checks it, optionally stalls, then transfers.
  task automatic handshake(input int unsigned hold);
    svc_t e;
    svc_t got;
    wait_valid();
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    got = {svc_nmi, svc_indirect, svc_vector};
    chk("svc_payload", 32'(got), 32'(e));
    for (int unsigned i = 0; i < hold; i++) begin
      ack_data = ack_data ^ 8'hFF;
      step();
      got = {svc_nmi, svc_indirect, svc_vector};
      chk("stall_valid", 32'(svc_valid), 32'd1);
      chk("stall_payload", 32'(got), 32'(e));
    end
    svc_ready = 1'b1;
    step();
    svc_ready = 1'b0;
    chk("xfer_valid_low", 32'(svc_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    step();
    step();
    chk("rst_iff1", 32'(iff1), 32'd0);
    chk("rst_iff2", 32'(iff2), 32'd0);
    chk("rst_im", 32'(im), 32'd0);
    chk("rst_intack", 32'(intack), 32'd0);
    chk("rst_svc", 32'({svc_valid, svc_nmi, svc_indirect, svc_vector}), 32'd0);
    reset_n = 1'b1;
    step();

    // Ready while nothing is offered must be harmless.
    svc_ready = 1'b1;
    step();
    svc_ready = 1'b0;
    chk("idle_ready_ignored", 32'(svc_valid), 32'd0);

    // IM1 with EI shadow.
    boundary(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    chk("im1_set", 32'(im), 32'd1);
    int_n = 1'b0;
    boundary(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("ei_iff", 32'({iff1, iff2}), 32'b11);
    chk("ei_no_accept", 32'(intack), 32'd0);
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("shadow_no_accept", 32'(intack), 32'd0);
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0038));
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    int_n = 1'b1;
    chk("int_ack_c1", 32'(intack), 32'd1);
    chk("int_iff_cleared", 32'({iff1, iff2}), 32'b00);
    chk("int_valid_c1", 32'(svc_valid), 32'd0);
    step();
    chk("int_ack_c2", 32'(intack), 32'd1);
    chk("int_valid_c2", 32'(svc_valid), 32'd0);
    step();
    chk("int_ack_c3", 32'(intack), 32'd0);
    chk("int_valid_c3", 32'(svc_valid), 32'd1);
    handshake(0);

    // IM2 table pointer with a 5-cycle stall.
    boundary(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    chk("im2_set", 32'(im), 32'd2);
    boundary(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    i_reg    = 8'h12;
    ack_data = 8'h35;
    int_n    = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 16'h1234));
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    int_n = 1'b1;
    handshake(5);

    // IM0 keeps only the RST bits of the opcode.
    boundary(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    chk("im0_set", 32'(im), 32'd0);
    boundary(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    ack_data = 8'hD7;
    int_n    = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0010));
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    int_n = 1'b1;
    handshake(0);

    boundary(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    chk("im3_as_im1", 32'(im), 32'd1);

    // NMI then RETN.
    boundary(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("pre_nmi_iff", 32'({iff1, iff2}), 32'b11);
    nmi_n = 1'b0;
    step();
    step();
    step();
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0066));
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("nmi_valid_next", 32'(svc_valid), 32'd1);
    chk("nmi_iff", 32'({iff1, iff2}), 32'b01);
    nmi_n = 1'b1;
    handshake(0);
    boundary(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("retn_iff", 32'({iff1, iff2}), 32'b11);

    // NMI and INT at the same boundary.
    nmi_n = 1'b0;
    step();
    step();
    step();
    int_n = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0066));
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("both_nmi_first", 32'(svc_nmi), 32'd1);
    chk("both_no_intack", 32'(intack), 32'd0);
    chk("both_iff", 32'({iff1, iff2}), 32'b01);
    handshake(0);
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("int_masked_after_nmi", 32'(intack), 32'd0);
    step();
    chk("no_offer_after_nmi", 32'(svc_valid), 32'd0);
    int_n = 1'b1;
    nmi_n = 1'b1;

    // Asynchronous reset in ACK2.
    boundary(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    int_n = 1'b0;
    boundary(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    int_n = 1'b1;
    chk("rst_seq_ack1", 32'(intack), 32'd1);
    step();
    chk("rst_seq_ack2", 32'(intack), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_intack", 32'(intack), 32'd0);
    chk("async_rst_valid", 32'(svc_valid), 32'd0);
    chk("async_rst_iff1", 32'(iff1), 32'd0);
    chk("async_rst_im", 32'(im), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_valid", 32'(svc_valid), 32'd0);
    chk("post_rst_intack", 32'(intack), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
